// File: rtl/source.sv
// Moore FSM counting consecutive 1s on b, saturating at 3; the state code is y.
// Latency: one clk edge from b to y; no backpressure, b is sampled on every edge.
module source (
  input  logic       clk,
  input  logic       rst,
  input  logic       b,
  output logic [1:0] y
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // All four codes are legal states, so no recovery branch is needed.
  always_comb begin
    state_d = S0;
    if (b) begin
      case (state_q)
        S0:      state_d = S1;
        S1:      state_d = S2;
        S2:      state_d = S3;
        default: state_d = S3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  assign y = state_q;

endmodule

// File: tb/tb_source.sv
// Scoreboard bench for source: a run-length model predicts y, a monitor compares after each edge.
module tb_source;

  logic       clk;
  logic       rst;
  logic       b;
  logic [1:0] y;

  int checks;
  int failures;
  int run;
  int sb_idx;
  logic [1:0] exp_q[$];

  source dut (
    .clk(clk),
    .rst(rst),
    .b  (b),
    .y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected value per sampled edge, compared 1 time unit after the edge.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y !== e) begin
          failures++;
          $display("FAIL scoreboard[%0d] t=%0t y=%b expected=%b", sb_idx, $time, y, e);
        end
        sb_idx++;
      end
    end
  end

  task automatic chk(input string name, input logic [1:0] exp);
    checks++;
    if (y !== exp) begin
      failures++;
      $display("FAIL %s t=%0t y=%b expected=%b", name, $time, y, exp);
    end
  endtask

  // Present bit bv for the next rising edge; glitch b afterwards to show only edges matter.
  task automatic step(input logic bv);
    logic [1:0] e;
    @(negedge clk);
    b   = bv;
    run = bv ? run + 1 : 0;
    e   = (run >= 3) ? 2'd3 : 2'(run);
    exp_q.push_back(e);
    @(posedge clk);
    #3;
    b = 1'($urandom);
  endtask

  // Assert reset away from any edge, hold two edges with b toggling, release away from edges.
  task automatic mid_reset();
    rst = 1'b0;
    #1;
    chk("rst_async", 2'd0);
    run = 0;
    repeat (2) begin
      @(posedge clk);
      b = ~b;
      #1;
      chk("rst_hold", 2'd0);
    end
    @(posedge clk);
    #3;
    b   = 1'b0;
    rst = 1'b1;
  endtask

  task automatic seq(input int n, input logic [15:0] bits);
    for (int i = 0; i < n; i++) begin
      logic [15:0] v;
      v = bits;
      step(v[n-1-i]);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    run      = 0;
    sb_idx   = 0;
    b        = 1'b0;
    rst      = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("reset_state", 2'd0);
    repeat (2) begin
      @(posedge clk);
      b = ~b;
      #1;
      chk("reset_hold", 2'd0);
    end
    @(posedge clk);
    #3;
    b   = 1'b0;
    rst = 1'b1;

    step(1'b0);                          // release with b=0
    seq(2, 16'b10);                      // 01, 00
    seq(4, 16'b1110);                    // 01 10 11 00
    seq(5, 16'b11111);                   // 01 10 11 11 11
    step(1'b0);
    seq(6, 16'b111010);                  // 01 10 11 00 01 00

    seq(2, 16'b11);                      // reach y=10
    mid_reset();
    step(1'b1);                          // first edge after release -> 01
    seq(3, 16'b111);                     // reach y=11
    mid_reset();
    seq(2, 16'b11);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        mid_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
